// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples SS/SCLK/MOSI in the clk domain, deserialises MSB-first
// frames into a valid/ack holding register and returns a preloaded word on MISO.
`timescale 1ns / 1ps

module spi_slave_rx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              abort,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DATA_W);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_q, sclk_q;
  logic                   rise_e, fall_e, sel_e;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              abort_q, abort_d;
  logic              complete;

  // Synchronisers start in the idle bus state so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_q        <= 1'b1;
      sclk_q      <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_q        <= ss_s;
      sclk_q      <= sclk_s;
    end
  end

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign rise_e = sclk_s & ~sclk_q;
  assign fall_e = ~sclk_s & sclk_q;
  assign sel_e  = ~ss_s & ss_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_buf_d   = tx_load ? tx_data : tx_buf_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ack;
    overrun_d  = 1'b0;
    abort_d    = 1'b0;
    complete   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel_e) begin
          state_d    = StShift;
          tx_shift_d = tx_buf_q;
          cnt_d      = '0;
        end
      end
      StShift: begin
        if (ss_s) begin
          abort_d = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else if (rise_e) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          cnt_d      = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d  = StHold;
            complete = 1'b1;
          end
        end else if (fall_e && (cnt_q < FullCnt)) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
        end
      end
      StHold: begin
        if (ss_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // An ack coinciding with completion frees the register, so it is not an overrun.
    if (complete) begin
      rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_s};
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q & ~rx_ack;
    end
  end

  assign busy     = (state_q != StIdle);
  assign miso_oe  = busy;
  assign miso     = miso_oe & tx_shift_q[DATA_W-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign abort    = abort_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: a bit-banged mode-0 master feeds frames, a scoreboard
// queue holds expected words and a negedge monitor pops, compares and acks them.
`timescale 1ns / 1ps

module tb_spi_slave_rx;

  localparam int DW    = 8;
  localparam int SYNC  = 2;
  localparam int CLK_P = 10;
  localparam int HALF  = 4;

  logic          clk = 1'b0;
  logic          rst, ss, sclk, mosi, tx_load;
  logic [DW-1:0] tx_data;
  logic          miso, miso_oe, rx_valid, overrun, abort, busy, rx_ack;
  logic [DW-1:0] rx_data;
  logic          ack_auto = 1'b0;
  logic          ack_dir  = 1'b0;

  assign rx_ack = ack_auto | ack_dir;

  spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .ss      (ss),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ack  (rx_ack),
    .overrun (overrun),
    .abort   (abort),
    .busy    (busy)
  );

  always #(CLK_P / 2) clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  bit            auto_mode = 1'b0;
  int            abort_cnt = 0;
  int            overrun_cnt = 0;
  time           valid_rise_t = 0;
  time           last_rise_t = 0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] tx_m = '0;
  logic          oe_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters, valid-rise timestamp, and scoreboard pop with a one-cycle ack.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid <= 1'b0;
      ack_auto   <= 1'b0;
    end else begin
      if (overrun) overrun_cnt <= overrun_cnt + 1;
      if (abort) abort_cnt <= abort_cnt + 1;
      if (rx_valid && !prev_valid) valid_rise_t <= $time;
      prev_valid <= rx_valid;
      if (ack_auto) begin
        ack_auto <= 1'b0;
      end else if (rx_valid && auto_mode) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_word: got 0x%0h expected none", rx_data);
        end else begin
          check("rx_word", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        ack_auto <= 1'b1;
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [DW-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    tx_m    = v;
  endtask

  task automatic pulse_ack();
    ack_dir = 1'b1;
    wait_clk(1);
    ack_dir = 1'b0;
    wait_clk(1);
  endtask

  task automatic spi_bit(input logic b, input bit ack_here, input bit do_load,
                         input logic [DW-1:0] load_val, output logic m);
    mosi = b;
    if (do_load) begin
      tx_data = load_val;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
      wait_clk(HALF - 1);
    end else begin
      wait_clk(HALF);
    end
    m = miso;
    if (!miso_oe) oe_bad = 1'b1;
    sclk        = 1'b1;
    last_rise_t = $time;
    if (ack_here) begin
      // Lands rx_ack on the exact edge that loads the completed word.
      wait_clk(SYNC);
      ack_dir = 1'b1;
      wait_clk(1);
      ack_dir = 1'b0;
      wait_clk(HALF - SYNC - 1);
    end else begin
      wait_clk(HALF);
    end
    sclk = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] d, input int nbits, input bit ack_last,
                       input bit mid_load, input logic [DW-1:0] mid_val, input int exp_ov);
    logic [DW-1:0] m_exp, got;
    logic          b;
    int            ab0, ov0;
    m_exp  = tx_m;
    got    = '0;
    ab0    = abort_cnt;
    ov0    = overrun_cnt;
    oe_bad = 1'b0;
    if (nbits == DW && auto_mode) exp_q.push_back(d);
    ss = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(d[DW-1-i], ack_last && (i == DW - 1), mid_load && (i == 3), mid_val, b);
      got = {got[DW-2:0], b};
    end
    if (mid_load) tx_m = mid_val;
    wait_clk(HALF);
    ss   = 1'b1;
    mosi = 1'b0;
    wait_clk(2 * HALF);
    check("miso_oe_in_frame", 32'(oe_bad), 0);
    if (nbits == DW) begin
      check("miso_word", 32'(got), 32'(m_exp));
      check("abort_none", 32'(abort_cnt - ab0), 0);
      if (auto_mode)
        check("valid_latency",
              32'((valid_rise_t > last_rise_t) &&
                  (valid_rise_t - last_rise_t <= (SYNC + 2) * CLK_P)), 1);
    end else begin
      check("abort_pulse", 32'(abort_cnt - ab0), 1);
    end
    check("overrun_cnt", 32'(overrun_cnt - ov0), 32'(exp_ov));
    check("idle_outputs", 32'({miso_oe, miso, busy}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic          b;
    logic [DW-1:0] d, v;
    rst     = 1'b0;
    ss      = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    wait_clk(3);
    check("reset_outputs", 32'({miso, miso_oe, rx_valid, overrun, abort, busy}), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    rst = 1'b1;
    wait_clk(3);

    pulse_ack();
    check("ack_idle_valid", 32'(rx_valid), 0);

    auto_mode = 1'b1;
    load_tx(8'h3C);
    frame(8'hA5, DW, 1'b0, 1'b0, '0, 0);
    check("valid_after_ack", 32'(rx_valid), 0);

    for (int n = 0; n < 16; n++) begin
      d = DW'($urandom);
      v = DW'($urandom);
      if ($urandom_range(0, 1) == 1) load_tx(DW'($urandom));
      frame(d, DW, 1'b0, $urandom_range(0, 1) == 1, v, 0);
    end

    auto_mode = 1'b0;
    frame(8'h11, DW, 1'b0, 1'b0, '0, 0);
    check("first_word", 32'(rx_data), 32'h11);
    frame(8'h22, DW, 1'b0, 1'b0, '0, 1);
    check("overrun_data", 32'(rx_data), 32'h22);
    check("overrun_valid", 32'(rx_valid), 1);
    pulse_ack();
    check("manual_ack", 32'(rx_valid), 0);

    frame(8'h33, DW, 1'b0, 1'b0, '0, 0);
    frame(8'h22, DW, 1'b1, 1'b0, '0, 0);
    check("ack_same_cycle_data", 32'(rx_data), 32'h22);
    check("ack_same_cycle_valid", 32'(rx_valid), 1);

    frame(8'h96, 5, 1'b0, 1'b0, '0, 0);
    check("abort_keeps_data", 32'(rx_data), 32'h22);
    check("abort_keeps_valid", 32'(rx_valid), 1);
    pulse_ack();
    auto_mode = 1'b1;
    frame(8'h5A, DW, 1'b0, 1'b0, '0, 0);

    load_tx(8'h81);
    ss = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, 1'b0, '0, b);
    rst = 1'b0;
    #2;
    check("midframe_reset_outputs", 32'({miso, miso_oe, rx_valid, overrun, abort, busy}), 0);
    check("midframe_reset_rx_data", 32'(rx_data), 0);
    tx_m = '0;
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(3);
    frame(8'hC3, DW, 1'b0, 1'b0, '0, 0);

    wait_clk(4);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
